adc_sample_sequencer: RTL and testbench

ADC_SAMPLE_SEQUENCER -- requirements
Module: adc_sample_sequencer

---
 rtl/adc_seq_pkg.sv | 44 ++++
 rtl/adc_seq_timeout.sv | 30 +++
 rtl/adc_sample_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_adc_sample_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC sample sequencer: scan FSM states,
// stream field widths, averaging depth and a mask-scan helper.
package adc_seq_pkg;

  localparam int unsigned ADC_DATA_W  = 12;
  localparam int unsigned ADC_CH_W    = 5;
  localparam int unsigned AVG_SAMPLES = 4;

  // Widest supported channel set; masks are zero-extended to this width
  localparam int unsigned MAX_CH = 8;
  // Index width able to hold MAX_CH itself, used as the "none found" value
  localparam int unsigned IDX_W  = 4;

  // Averaging accumulator and sample-counter widths
  localparam int unsigned SAMP_W = $clog2(AVG_SAMPLES);
  localparam int unsigned ACC_W  = ADC_DATA_W + SAMP_W;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    NEXT,
    DONE
  } state_t;

  // Lowest set mask bit at or above 'from'; returns MAX_CH when none remain
  function automatic logic [IDX_W-1:0] first_set_from(
    input logic [MAX_CH-1:0] mask,
    input logic [IDX_W-1:0]  from
  );
    logic [IDX_W-1:0] pos;
    logic             found;
    pos   = IDX_W'(MAX_CH);
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (!found && mask[i] && (IDX_W'(i) >= from)) begin
        pos   = IDX_W'(i);
        found = 1'b1;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/adc_seq_timeout.sv
// Response timeout counter: cleared on command transfer, counts while
// enabled, and flags expiry on the CYCLES-th enabled cycle.
module adc_seq_timeout #(
  parameter int unsigned CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] r_count;

  assign o_expired = i_enable && (r_count == CW'(CYCLES - 1));

  // Count enabled cycles, holding at the expiry value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/adc_sample_sequencer.sv
// ADC sample sequencer: scans the channels enabled in chan_mask, issuing
// one single-beat command per sample and storing each response in result.
// Optional macro ADC_SEQ_AVG_EN: take AVG_SAMPLES samples per channel and
// store their truncated mean.
module adc_sample_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned NUM_CH         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  input  logic                         start,
  input  logic [NUM_CH-1:0]            chan_mask,
  output logic                         cmd_valid,
  output logic                         cmd_sop,
  output logic                         cmd_eop,
  output logic [ADC_CH_W-1:0]          cmd_channel,
  input  logic                         cmd_ready,
  input  logic                         rsp_valid,
  input  logic [ADC_CH_W-1:0]          rsp_channel,
  input  logic [ADC_DATA_W-1:0]        rsp_data,
  output logic [ADC_DATA_W*NUM_CH-1:0] result,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [NUM_CH-1:0]            r_mask;
  logic [IDX_W-1:0]             r_index;
  logic [ADC_DATA_W*NUM_CH-1:0] r_result;
  logic                         r_error;

  logic [MAX_CH-1:0]            w_start_mask8;
  logic [MAX_CH-1:0]            w_mask8;
  logic [IDX_W-1:0]             w_first_idx;
  logic [IDX_W-1:0]             w_next_idx;
  logic                         w_next_none;
  logic [ADC_CH_W-1:0]          w_chan;
  logic                         w_accept;
  logic                         w_xfer;
  logic                         w_waiting;
  logic                         w_hit;
  logic                         w_miss;
  logic                         w_expired;
  logic                         w_last_sample;
  logic                         w_wr;
  logic [ADC_DATA_W-1:0]        w_wdata;

  assign w_start_mask8 = MAX_CH'(chan_mask);
  assign w_mask8       = MAX_CH'(r_mask);
  assign w_first_idx   = first_set_from(w_start_mask8, '0);
  assign w_next_idx    = first_set_from(w_mask8, r_index + IDX_W'(1));
  assign w_next_none   = (w_next_idx == IDX_W'(MAX_CH));
  assign w_chan        = ADC_CH_W'(r_index) + ADC_CH_W'(1);

  assign w_accept  = (r_state == IDLE) && start;
  assign w_xfer    = (r_state == ISSUE) && cmd_ready;
  assign w_waiting = (r_state == WAIT_RSP);
  assign w_hit     = w_waiting && rsp_valid && (rsp_channel == w_chan);
  assign w_miss    = w_waiting && rsp_valid && (rsp_channel != w_chan);

  adc_seq_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .i_clear   (w_xfer),
    .i_enable  (w_waiting),
    .o_expired (w_expired)
  );

`ifdef ADC_SEQ_AVG_EN
  logic [ACC_W-1:0]  r_acc;
  logic [SAMP_W-1:0] r_samp;
  logic [ACC_W-1:0]  w_sum;

  assign w_sum         = r_acc + ACC_W'(rsp_data);
  assign w_last_sample = (r_samp == SAMP_W'(AVG_SAMPLES - 1));
  assign w_wr          = w_hit && w_last_sample;
  assign w_wdata       = w_sum[ACC_W-1 -: ADC_DATA_W];

  // Per-channel sample accumulation, restarted whenever a new channel is picked
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_acc  <= '0;
      r_samp <= '0;
    end else if (w_accept || (r_state == NEXT)) begin
      r_acc  <= '0;
      r_samp <= '0;
    end else if (w_hit) begin
      r_acc  <= w_sum;
      r_samp <= r_samp + SAMP_W'(1);
    end
  end
`else
  assign w_last_sample = 1'b1;
  assign w_wr          = w_hit;
  assign w_wdata       = rsp_data;
`endif

  // Scan state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and command/status decode
  always_comb begin
    w_state_nxt = r_state;
    cmd_valid   = 1'b0;
    cmd_sop     = 1'b0;
    cmd_eop     = 1'b0;
    cmd_channel = '0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = (chan_mask == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        cmd_valid   = 1'b1;
        cmd_sop     = 1'b1;
        cmd_eop     = 1'b1;
        cmd_channel = w_chan;
        if (cmd_ready) begin
          w_state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // A matching response wins over a coincident timeout
        if (w_hit) begin
          w_state_nxt = w_last_sample ? NEXT : ISSUE;
        end else if (w_expired) begin
          w_state_nxt = NEXT;
        end
      end
      NEXT: begin
        w_state_nxt = w_next_none ? DONE : ISSUE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Mask latch, channel selection and sticky error
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_mask  <= '0;
      r_index <= '0;
      r_error <= 1'b0;
    end else if (w_accept) begin
      r_mask  <= chan_mask;
      r_index <= (chan_mask == '0) ? '0 : w_first_idx;
      r_error <= 1'b0;
    end else begin
      if ((r_state == NEXT) && !w_next_none) begin
        r_index <= w_next_idx;
      end
      if (w_miss || (w_expired && !w_hit)) begin
        r_error <= 1'b1;
      end
    end
  end

  // Per-channel result storage
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_result <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (w_wr && (r_index == IDX_W'(c))) begin
          r_result[c*ADC_DATA_W +: ADC_DATA_W] <= w_wdata;
        end
      end
    end
  end

  assign result = r_result;
  assign error  = r_error;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Scoreboard bench for adc_sample_sequencer. The planner derives, from the
// channel mask and the chosen ADC behaviour per sample, the command channel
// order and the final result/error; the driver plays the ADC; monitors pop
// and compare on each command transfer and each done pulse.
`timescale 1ns/1ps
module tb_adc_sample_sequencer;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned TO     = 16;
  localparam int unsigned BOUND  = 3*TO + 20;
`ifdef ADC_SEQ_AVG_EN
  localparam int unsigned SAMPLES = 4;
`else
  localparam int unsigned SAMPLES = 1;
`endif

  logic               clk_clk;
  logic               reset_reset_n;
  logic               start;
  logic [NUM_CH-1:0]  chan_mask;
  logic               cmd_valid, cmd_sop, cmd_eop;
  logic [4:0]         cmd_channel;
  logic               cmd_ready;
  logic               rsp_valid;
  logic [4:0]         rsp_channel;
  logic [11:0]        rsp_data;
  logic [12*NUM_CH-1:0] result;
  logic               busy, done, error;

  adc_sample_sequencer #(
    .NUM_CH         (NUM_CH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .start         (start),
    .chan_mask     (chan_mask),
    .cmd_valid     (cmd_valid),
    .cmd_sop       (cmd_sop),
    .cmd_eop       (cmd_eop),
    .cmd_channel   (cmd_channel),
    .cmd_ready     (cmd_ready),
    .rsp_valid     (rsp_valid),
    .rsp_channel   (rsp_channel),
    .rsp_data      (rsp_data),
    .result        (result),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  // kind: 0 good response, 1 wrong channel then good, 2 no response
  typedef struct {
    int unsigned ch;
    int unsigned rdy_dly;
    int unsigned kind;
    int unsigned rsp_dly;
    logic [11:0] data;
    logic [4:0]  wrong;
    bit          chk_to;
  } op_t;

  typedef struct {
    logic [12*NUM_CH-1:0] res;
    logic                 err;
  } done_t;

  op_t         ops[$];
  int unsigned exp_cmd_q[$];
  done_t       exp_done_q[$];
  logic [11:0] m_res   [NUM_CH];
  logic        m_err;
  logic [11:0] dir_data[NUM_CH];
  int          compared;
  int          mismatched;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  // Reference model: work out the command order and end-of-scan state
  task automatic plan_scan(input logic [7:0] mask, input bit directed,
                           input int unsigned d_kind, input int unsigned d_rdy,
                           input logic [4:0] d_wrong, input int unsigned d_inc);
    op_t         op;
    done_t       dn;
    int unsigned sum;
    bit          aborted;
    ops.delete();
    m_err = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c]) begin
        sum     = 0;
        aborted = 1'b0;
        for (int s = 0; s < SAMPLES && !aborted; s++) begin
          op.ch     = c + 1;
          op.chk_to = !m_err;
          if (directed) begin
            op.kind    = d_kind;
            op.rdy_dly = d_rdy;
            op.rsp_dly = 3;
            op.data    = dir_data[c] + 12'(s * d_inc);
            op.wrong   = d_wrong;
          end else begin
            op.kind    = ($urandom_range(0, 7) == 0) ? 2 : (($urandom_range(0, 4) == 0) ? 1 : 0);
            op.rdy_dly = $urandom_range(0, 3);
            op.rsp_dly = $urandom_range(0, 4);
            op.data    = 12'($urandom);
            op.wrong   = 5'((c + 1 + $urandom_range(1, 30)) % 32);
          end
          ops.push_back(op);
          exp_cmd_q.push_back(c + 1);
          if (op.kind == 2) begin
            m_err   = 1'b1;
            aborted = 1'b1;
          end else begin
            if (op.kind == 1) m_err = 1'b1;
            sum += op.data;
          end
        end
        if (!aborted) m_res[c] = 12'(sum / SAMPLES);
      end
    end
    for (int c = 0; c < NUM_CH; c++) dn.res[c*12 +: 12] = m_res[c];
    dn.err = m_err;
    exp_done_q.push_back(dn);
  endtask

  task automatic wait_for_cmd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      if (cmd_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("cmd_wait", ok, 1);
  endtask

  // Driver: start the scan and play the ADC for every planned sample
  task automatic run_scan(input logic [7:0] mask);
    bit ok;
    chan_mask = mask;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    chan_mask = 8'($urandom);
    foreach (ops[k]) begin
      wait_for_cmd(ok);
      if (!ok) break;
      for (int unsigned d = 0; d < ops[k].rdy_dly; d++) begin
        chk("issue_hold", {cmd_valid, cmd_sop, cmd_eop, busy, cmd_channel}, {4'hF, 5'(ops[k].ch)});
        rsp_valid   = 1'($urandom_range(0, 1));
        rsp_channel = 5'(ops[k].ch);
        rsp_data    = 12'($urandom);
        start       = 1'($urandom_range(0, 1));
        chan_mask   = 8'($urandom);
        tick();
        rsp_valid = 1'b0;
        start     = 1'b0;
      end
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      case (ops[k].kind)
        0: begin
          repeat (ops[k].rsp_dly) tick();
          rsp_valid   = 1'b1;
          rsp_channel = 5'(ops[k].ch);
          rsp_data    = ops[k].data;
          tick();
          rsp_valid = 1'b0;
        end
        1: begin
          rsp_valid   = 1'b1;
          rsp_channel = ops[k].wrong;
          rsp_data    = 12'($urandom);
          tick();
          rsp_channel = 5'(ops[k].ch);
          rsp_data    = ops[k].data;
          tick();
          rsp_valid = 1'b0;
        end
        default: begin
          if (ops[k].chk_to) begin
            repeat (TO - 1) tick();
            chk("timeout_early", error, 0);
            tick();
            chk("timeout_flag", error, 1);
          end
        end
      endcase
    end
    ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("scan_idle", ok, 1);
    chk("done_pending", exp_done_q.size(), 0);
    chk("cmd_pending", exp_cmd_q.size(), 0);
    exp_done_q.delete();
    exp_cmd_q.delete();
  endtask

  // Monitor: compare each command transfer and each completion pulse
  initial begin
    int unsigned e;
    done_t       d;
    forever begin
      @(negedge clk_clk);
      if (reset_reset_n) begin
        if (cmd_valid && cmd_ready) begin
          if (exp_cmd_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL cmd_unexpected: got channel %0d, expected no command", cmd_channel);
          end else begin
            e = exp_cmd_q.pop_front();
            chk("cmd_channel", cmd_channel, e);
          end
        end
        if (done) begin
          if (exp_done_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL done_unexpected: got done=1, expected no completion");
          end else begin
            d = exp_done_q.pop_front();
            chk("done_result", result, d.res);
            chk("done_error", error, d.err);
            chk("done_busy", busy, 1);
          end
        end
      end
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] mk;
    bit         ok;
    compared      = 0;
    mismatched    = 0;
    reset_reset_n = 1'b0;
    start         = 1'b0;
    chan_mask     = '0;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_channel   = '0;
    rsp_data      = '0;
    m_err         = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_res[c]    = '0;
      dir_data[c] = '0;
    end
    repeat (3) tick();
    chk("reset_ctrl", {cmd_valid, cmd_sop, cmd_eop, cmd_channel, busy, done, error}, 0);
    chk("reset_result", result, 0);
    reset_reset_n = 1'b1;

    // Empty mask: completion pulse with no command
    plan_scan(8'h00, 1'b1, 0, 0, 5'd0, 0);
    run_scan(8'h00);

    // Channels 1 and 3, responses three cycles after transfer
    dir_data[0] = 12'h123;
    dir_data[2] = 12'hABC;
    plan_scan(8'h05, 1'b1, 0, 0, 5'd0, 0);
    run_scan(8'h05);

    // Ready withheld for 20 cycles
    dir_data[0] = 12'($urandom);
    plan_scan(8'h01, 1'b1, 0, 20, 5'd0, 0);
    run_scan(8'h01);

    // No responses at all
    plan_scan(8'h03, 1'b1, 2, 0, 5'd0, 0);
    run_scan(8'h03);

    // Stray channel 5 response before the expected channel 2 one
    dir_data[1] = 12'h055;
    plan_scan(8'h02, 1'b1, 1, 0, 5'd5, 0);
    run_scan(8'h02);

    // Rising sample sequence 0x100.. on channel 1
    dir_data[0] = 12'h100;
    plan_scan(8'h01, 1'b1, 0, 1, 5'd0, 1);
    run_scan(8'h01);

    for (int n = 0; n < 25; n++) begin
      mk = 8'($urandom_range(1, 255));
      plan_scan(mk, 1'b0, 0, 0, 5'd0, 0);
      run_scan(mk);
    end

    // Reset while a response is outstanding
    chan_mask = 8'h01;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    exp_cmd_q.push_back(1);
    wait_for_cmd(ok);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    repeat (2) tick();
    chk("pre_reset_busy", busy, 1);
    reset_reset_n = 1'b0;
    #1;
    chk("midscan_reset_ctrl", {cmd_valid, cmd_sop, cmd_eop, cmd_channel, busy, done, error}, 0);
    chk("midscan_reset_result", result, 0);
    chk("midscan_cmd_pending", exp_cmd_q.size(), 0);
    exp_cmd_q.delete();
    repeat (2) tick();
    reset_reset_n = 1'b1;
    for (int c = 0; c < NUM_CH; c++) m_res[c] = '0;
    m_err = 1'b0;

    for (int n = 0; n < 3; n++) begin
      mk = 8'($urandom_range(1, 255));
      plan_scan(mk, 1'b0, 0, 0, 5'd0, 0);
      run_scan(mk);
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
